// File: rtl/fp32_dot_accumulator_if.sv
// Product-in / result-out handshake bundle for one dot-product accumulator lane.
interface fp32_dot_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_prod;
  logic             i_ovf;
  logic             i_last;
  logic             o_valid;
  logic             i_out_ready;
  logic [31:0]      o_sum;
  logic             o_overflow;
  logic [CNT_W-1:0] o_count;

  modport master (
    output i_valid, i_prod, i_ovf, i_last, i_out_ready,
    input  o_ready, o_valid, o_sum, o_overflow, o_count
  );

  modport slave (
    input  i_valid, i_prod, i_ovf, i_last, i_out_ready,
    output o_ready, o_valid, o_sum, o_overflow, o_count
  );
endinterface

// File: rtl/fp32_dot_accumulator.sv
// Sequential FP32 accumulator: sums multiplier products with a 3-cycle
// align/add/normalize datapath (truncating) and presents the element on i_last.
module fp32_dot_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fp32_dot_accumulator_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;
  state_t state_q, state_d;

  logic [31:0]      acc_q, prod_q;
  logic             last_q, sticky_q;
  logic [CNT_W-1:0] cnt_q;

  logic             spec_q;
  logic [31:0]      spec_val_q;
  logic             sgn_q, sub_q, zsgn_q;
  logic [7:0]       exp_q;
  logic [26:0]      big_m_q, sml_m_q;
  logic [27:0]      sum_q;

  logic [31:0]      sum_out_q;
  logic             ovf_out_q;
  logic [CNT_W-1:0] cnt_out_q;

  logic accept;

  assign bus.o_ready    = (state_q == IDLE) && !i_rst;
  assign bus.o_valid    = (state_q == OUT);
  assign bus.o_sum      = sum_out_q;
  assign bus.o_overflow = ovf_out_q;
  assign bus.o_count    = cnt_out_q;
  assign accept         = bus.i_valid && bus.o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = last_q ? OUT : IDLE;
      OUT:     if (bus.i_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // Align: the larger magnitude becomes the base so subtraction never goes negative
  logic        a_ge, nan_a, nan_b, inf_a, inf_b, spec_d;
  logic [31:0] big, sml, spec_val_d;
  logic [7:0]  big_e, sml_e, diff;
  logic [23:0] sml_man;
  logic [26:0] big_m_d, sml_sh;

  always_comb begin
    a_ge    = acc_q[30:0] >= prod_q[30:0];
    big     = a_ge ? acc_q : prod_q;
    sml     = a_ge ? prod_q : acc_q;
    big_e   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    sml_e   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    diff    = big_e - sml_e;
    big_m_d = {big[30:23] != 8'd0, big[22:0], 3'b000};
    sml_man = {sml[30:23] != 8'd0, sml[22:0]};
    sml_sh  = (diff >= 8'd27) ? 27'd0 : ({sml_man, 3'b000} >> diff);
    nan_a   = (&acc_q[30:23])  && (|acc_q[22:0]);
    nan_b   = (&prod_q[30:23]) && (|prod_q[22:0]);
    inf_a   = (&acc_q[30:23])  && !(|acc_q[22:0]);
    inf_b   = (&prod_q[30:23]) && !(|prod_q[22:0]);
    spec_d  = nan_a || nan_b || inf_a || inf_b;
    spec_val_d = prod_q;
    if (nan_a || nan_b || (inf_a && inf_b && (acc_q[31] != prod_q[31])))
      spec_val_d = 32'h7FC00000;
    else if (inf_a)
      spec_val_d = acc_q;
  end

  logic [27:0] add_d;
  always_comb begin
    add_d = sub_q ? ({1'b0, big_m_q} - {1'b0, sml_m_q})
                  : ({1'b0, big_m_q} + {1'b0, sml_m_q});
  end

  // Normalize and truncate; guard bits below nm[3] are simply dropped
  logic [4:0]        lz;
  logic [26:0]       nm;
  logic signed [9:0] ne;
  logic [31:0]       res;
  logic              res_ovf;
  logic              unused_bits;

  always_comb begin
    lz      = lzc27(sum_q[26:0]);
    nm      = sum_q[26:0] << lz;
    ne      = $signed({2'b00, exp_q}) - $signed({5'b00000, lz});
    if (sum_q[27]) begin
      nm = sum_q[27:1];
      ne = $signed({2'b00, exp_q}) + 10'sd1;
    end
    res     = {sgn_q, ne[7:0], nm[25:3]};
    res_ovf = 1'b0;
    if (spec_q) begin
      res     = spec_val_q;
      res_ovf = 1'b1;
    end else if (sum_q == 28'd0 || ne <= 10'sd0) begin
      res = {zsgn_q, 31'd0};
    end else if (ne >= 10'sd255) begin
      res     = {sgn_q, 8'hFF, 23'd0};
      res_ovf = 1'b1;
    end
  end

  assign unused_bits = ^{nm[26], nm[2:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q      <= '0;
      prod_q     <= '0;
      last_q     <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      sgn_q      <= 1'b0;
      sub_q      <= 1'b0;
      zsgn_q     <= 1'b0;
      exp_q      <= '0;
      big_m_q    <= '0;
      sml_m_q    <= '0;
      sum_q      <= '0;
      sum_out_q  <= '0;
      ovf_out_q  <= 1'b0;
      cnt_out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          prod_q   <= bus.i_prod;
          last_q   <= bus.i_last;
          sticky_q <= sticky_q | bus.i_ovf;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
        ALIGN: begin
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
          sgn_q      <= big[31];
          sub_q      <= big[31] ^ sml[31];
          zsgn_q     <= big[31] & sml[31];
          exp_q      <= big_e;
          big_m_q    <= big_m_d;
          sml_m_q    <= sml_sh;
        end
        ADD: sum_q <= add_d;
        NORM: begin
          acc_q    <= res;
          sticky_q <= sticky_q | res_ovf;
          if (last_q) begin
            sum_out_q <= res;
            ovf_out_q <= sticky_q | res_ovf;
            cnt_out_q <= cnt_q;
          end
        end
        OUT: if (bus.i_out_ready) begin
          acc_q    <= '0;
          cnt_q    <= '0;
          sticky_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Scoreboard bench for fp32_dot_accumulator: expected elements are queued as
// terms are driven and popped when o_valid appears.
module tb_fp32_dot_accumulator;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]      sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  fp32_dot_accumulator_if #(.CNT_W(CNT_W)) bus();

  fp32_dot_accumulator #(.CNT_W(CNT_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  task automatic expect_result(input logic [31:0] s, input logic o, input int c);
    exp_t e;
    e.sum = s; e.ovf = o; e.cnt = c[CNT_W-1:0];
    sb.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_term(input logic [31:0] p, input logic ovf, input logic last, output int t);
    bit ok = 1'b0;
    t = 0;
    bus.i_valid = 1'b1; bus.i_prod = p; bus.i_ovf = ovf; bus.i_last = last;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus.o_ready === 1'b1) begin ok = 1'b1; t = cyc; end
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0; bus.i_ovf = 1'b0; bus.i_last = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout prod %h never accepted (o_ready %b)", p, bus.o_ready);
    end
  endtask

  task automatic wait_result(output logic [31:0] s, output logic o, output logic [CNT_W-1:0] c,
                             output int t, output bit ok);
    ok = 1'b0; s = '0; o = 1'b0; c = '0; t = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.o_valid === 1'b1) begin
        s = bus.o_sum; o = bus.o_overflow; c = bus.o_count; t = cyc; ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid timeout at cycle %0d", cyc);
    end
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_prod = '0; bus.i_ovf = 1'b0; bus.i_last = 1'b0;
    bus.i_out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready got %b want 0", bus.o_ready);
    end
    n_cmp++;
    if ({bus.o_valid, bus.o_sum, bus.o_overflow, bus.o_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got v%b %h %b %0d want all 0",
               bus.o_valid, bus.o_sum, bus.o_overflow, bus.o_count);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_ready got %b want 1", bus.o_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    logic [31:0] ta[5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 32'h80000000};
    logic [31:0] tb[5] = '{32'h40000000, 32'hBF800000, 32'h33800000, 32'hC0000000, 32'h80000000};
    logic [31:0] ts[5] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h00000000};
    exp_t e; logic [31:0] gs; logic go; logic [CNT_W-1:0] gc; int t0, t1, tv; bit ok;
    for (int i = 0; i < 5; i++) begin
      expect_result(ts[i], 1'b0, 2);
      send_term(ta[i], 1'b0, 1'b0, t0);
      send_term(tb[i], 1'b0, 1'b1, t1);
      wait_result(gs, go, gc, tv, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {gs, go, gc} !== {e.sum, e.ovf, e.cnt}) begin
        n_bad++;
        $display("FAIL arith[%0d] got %h/%b/%0d want %h/%b/%0d", i, gs, go, gc, e.sum, e.ovf, e.cnt);
      end
      n_cmp++;
      if (tv - t1 !== 4) begin
        n_bad++; $display("FAIL arith_latency[%0d] got %0d want 4", i, tv - t1);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.o_valid, bus.o_ready, bus.o_sum} !== {1'b0, 1'b1, e.sum}) begin
        n_bad++;
        $display("FAIL arith_release[%0d] got v%b r%b %h want v0 r1 %h",
                 i, bus.o_valid, bus.o_ready, bus.o_sum, e.sum);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ta[5] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F800000, 32'h7F800000, 32'h3F800000};
    logic        oa[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] tb[5] = '{32'h7F7FFFFF, 32'h3F800000, 32'hFF800000, 32'h3F800000, 32'h7F800001};
    logic [31:0] ts[5] = '{32'h7F800000, 32'h40000000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000};
    exp_t e; logic [31:0] gs; logic go; logic [CNT_W-1:0] gc; int t0, t1, tv; bit ok;
    for (int i = 0; i < 5; i++) begin
      expect_result(ts[i], 1'b1, 2);
      send_term(ta[i], oa[i], 1'b0, t0);
      send_term(tb[i], 1'b0, 1'b1, t1);
      wait_result(gs, go, gc, tv, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {gs, go, gc} !== {e.sum, e.ovf, e.cnt}) begin
        n_bad++;
        $display("FAIL overflow[%0d] got %h/%b/%0d want %h/%b/%0d", i, gs, go, gc, e.sum, e.ovf, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_term();
    logic [31:0] tx[3] = '{32'h00000001, 32'hBF800000, 32'h40000000};
    logic [31:0] ts[3] = '{32'h00000000, 32'hBF800000, 32'h40000000};
    exp_t e; logic [31:0] gs; logic go; logic [CNT_W-1:0] gc; int t1, tv; bit ok;
    for (int i = 0; i < 3; i++) begin
      expect_result(ts[i], 1'b0, 1);
      send_term(tx[i], 1'b0, 1'b1, t1);
      wait_result(gs, go, gc, tv, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {gs, go, gc} !== {e.sum, e.ovf, e.cnt}) begin
        n_bad++;
        $display("FAIL single[%0d] got %h/%b/%0d want %h/%b/%0d", i, gs, go, gc, e.sum, e.ovf, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_count_saturate();
    exp_t e; logic [31:0] gs; logic go; logic [CNT_W-1:0] gc; int t, tv; bit ok;
    expect_result(32'h41880000, 1'b0, 15);
    for (int i = 0; i < 17; i++) send_term(32'h3F800000, 1'b0, i == 16, t);
    wait_result(gs, go, gc, tv, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {gs, go, gc} !== {e.sum, e.ovf, e.cnt}) begin
      n_bad++;
      $display("FAIL count_sat got %h/%b/%0d want %h/%b/%0d", gs, go, gc, e.sum, e.ovf, e.cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e; logic [31:0] gs; logic go; logic [CNT_W-1:0] gc; int t0, t1, tv; bit ok;
    bus.i_out_ready = 1'b0;
    expect_result(32'h40400000, 1'b0, 2);
    send_term(32'h3F800000, 1'b0, 1'b0, t0);
    send_term(32'h40000000, 1'b0, 1'b1, t1);
    wait_result(gs, go, gc, tv, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {gs, go, gc} !== {e.sum, e.ovf, e.cnt} || tv - t1 !== 4) begin
      n_bad++;
      $display("FAIL bp_result got %h/%b/%0d lat %0d want %h/%b/%0d lat 4",
               gs, go, gc, tv - t1, e.sum, e.ovf, e.cnt);
    end
    for (int k = 0; k < 5; k++) begin
      bus.i_valid = k[0]; bus.i_prod = 32'h3F800000; bus.i_last = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.o_valid, bus.o_ready, bus.o_sum, bus.o_count} !==
          {1'b1, 1'b0, 32'h40400000, CNT_W'(2)}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got v%b r%b %h %0d want v1 r0 40400000 2",
                 k, bus.o_valid, bus.o_ready, bus.o_sum, bus.o_count);
      end
    end
    bus.i_valid = 1'b0; bus.i_last = 1'b0; bus.i_out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.o_valid, bus.o_ready} !== 2'b01) begin
      n_bad++; $display("FAIL bp_release got v%b r%b want v0 r1", bus.o_valid, bus.o_ready);
    end
    expect_result(32'h40000000, 1'b0, 1);
    send_term(32'h40000000, 1'b0, 1'b1, t1);
    wait_result(gs, go, gc, tv, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {gs, go, gc} !== {e.sum, e.ovf, e.cnt}) begin
      n_bad++;
      $display("FAIL bp_fresh got %h/%b/%0d want %h/%b/%0d", gs, go, gc, e.sum, e.ovf, e.cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    exp_t e; logic [31:0] gs; logic go; logic [CNT_W-1:0] gc; int t, tv; bit ok;
    send_term(32'h3F800000, 1'b1, 1'b0, t);
    send_term(32'h3F800000, 1'b0, 1'b0, t);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.o_valid, bus.o_ready, bus.o_sum, bus.o_overflow, bus.o_count} !== '0) begin
      n_bad++;
      $display("FAIL midop_reset got v%b r%b %h %b %0d want all 0",
               bus.o_valid, bus.o_ready, bus.o_sum, bus.o_overflow, bus.o_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_result(32'h40000000, 1'b0, 1);
    send_term(32'h40000000, 1'b0, 1'b1, t);
    wait_result(gs, go, gc, tv, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {gs, go, gc} !== {e.sum, e.ovf, e.cnt}) begin
      n_bad++;
      $display("FAIL midop_after got %h/%b/%0d want %h/%b/%0d", gs, go, gc, e.sum, e.ovf, e.cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_overflow();
    test_single_term();
    test_count_saturate();
    test_backpressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp32_dot_accumulator.md
Name: fp32_dot_accumulator

Overview:
- Sequential FP32 accumulator directly downstream of the 32-bit FP multiplier.
- Consumes a stream of single-precision products (result word plus overflow flag) over a valid/ready handshake and sums them with a multi-cycle add datapath.
- Presents the completed dot-product element, a sticky overflow flag and a term count when the input marks the last term.
- One instance per output-matrix element lane.

Parameters:
CNT_W, 8, width of the term counter and o_count; counter saturates at 2^CNT_W-1.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_valid  input  1  product word valid
o_ready  output  1  block can accept a product this cycle
i_prod  input  32  FP32 product from multiplier
i_ovf  input  1  multiplier overflow flag for this product
i_last  input  1  product is final term of the element
o_valid  output  1  result valid
i_out_ready  input  1  downstream accepts result
o_sum  output  32  accumulated FP32 sum
o_overflow  output  1  sticky OR of i_ovf and adder overflow over the element
o_count  output  CNT_W  number of terms accumulated

Behaviour:
- Reset (async, any state): state=IDLE, accumulator=+0.0 (32'h00000000), o_ready=0 during reset and 1 in the first cycle after reset, o_valid=0, o_sum=0, o_overflow=0, o_count=0, sticky flags cleared.
- States: IDLE, ALIGN, ADD, NORM, OUT.
- IDLE: o_ready=1. On i_valid&&o_ready:
  - Capture i_prod and i_last.
  - OR i_ovf into sticky overflow; increment count (saturating).
  - Go to ALIGN.
- ALIGN, ADD, NORM: o_ready=0. One cycle each. One product is absorbed every 4 cycles at best.
- ALIGN:
  - Unpack both operands. Hidden bit 1 if exp!=0, else 0 with effective exp 1.
  - Larger-exponent operand is the base.
  - Right-shift the smaller 24-bit mantissa by the exp difference into a 27-bit field (24 + 3 guard bits). Difference >=27 contributes 0.
- ADD: signed-magnitude add/subtract in 28 bits. Result sign = sign of the larger magnitude.
- NORM, normal path:
  - Carry out: shift right 1, exp+1.
  - Otherwise: left-shift by leading-zero count, exp-=lzc.
  - Rounding is truncation (round toward zero); guard bits are discarded.
- NORM, boundary rules:
  - exp>=255 after normalize: result {sign,8'hFF,23'b0}; set sticky overflow.
  - exp<=0 or zero magnitude: flush to zero. Exact cancellation gives +0.0. Sum of two zeros gives +0 unless both are -0.
- NORM exit: write result to accumulator. Go to OUT if captured last=1, else IDLE.
- Special cases, resolved in ALIGN; the value is written in NORM with no arithmetic:
  - Either operand NaN, or +inf plus -inf: 32'h7FC00000; sticky overflow set.
  - Either operand inf (not both opposite): that inf; sticky overflow set.
  - A NaN or inf accumulator persists until the element completes.
- OUT: o_valid=1. o_sum, o_overflow and o_count are stable. o_ready=0.
  - On i_out_ready: o_valid falls next cycle; accumulator, count and sticky flag clear to 0; go to IDLE.
  - i_out_ready low: hold indefinitely (backpressure).
- i_valid while o_ready=0 is ignored; the upstream must hold it.
- Latency: the last term accepted on cycle T gives o_valid high on cycle T+4.
- Single term with i_last=1: o_sum equals 0+x, i.e. x (denormal x flushes to 0).
- o_sum/o_overflow/o_count registered; they show the last completed element's values outside OUT, and 0 after reset.

Test Plan:
- 3F800000 then 40000000 (last) with i_out_ready=1 -> o_valid 4 cycles after second accept; o_sum=40400000, o_count=2, o_overflow=0.
- 3F800000 then BF800000 (last) -> o_sum=00000000 (+0), o_overflow=0.
- 7F7FFFFF then 7F7FFFFF (last) -> o_sum=7F800000, o_overflow=1. Separately, 3F800000 with i_ovf=1 then 3F800000 (last) -> o_sum=40000000, o_overflow=1.
- 7F800000 then FF800000 (last) -> o_sum=7FC00000, o_overflow=1. Separately, 3F800000 then 33800000 (last) (exp diff 24) -> o_sum=3F800000 (truncated).
- Backpressure: result 40400000 with i_out_ready low 5 cycles -> o_valid and o_sum held; o_ready=0; i_valid pulses ignored. Raise i_out_ready -> next cycle o_valid=0, o_ready=1; next element starts from +0.
- Reset mid-op: assert i_rst during ADD of the second of three terms -> all outputs 0 immediately. After release, 40000000 (last) gives o_sum=40000000, o_count=1.
